// File: rtl/ws2812_ctrl.sv
// ---------------------------------------------------------------------------
// ws2812_ctrl
//
// Serialises a frame of LED_NUM 24-bit GRB pixels onto a single WS2812 data
// line, then holds the line low for the latch gap. Pixels are fetched one at
// a time from an external pixel-select block. cfg_start asks that block to
// advance to the next pixel, and cfg_data is sampled in the LOAD cycle.
//
// Ports
//   sys_clk       in   sole clock, rising edge
//   sys_rst       in   asynchronous active-high reset
//   ws2812_start  in   single-cycle frame request
//   cfg_data      in   [23:0] current pixel colour, bit 23 transmitted first
//   cfg_start     out  one-cycle pulse: pixel consumed, advance the index
//   dout          out  registered WS2812 serial line
//   busy          out  high from frame acceptance until the frame ends
//   frame_done    out  one-cycle pulse on the last cycle of the latch gap
//
// All outputs are registered. Each output is computed from the next-state
// values, so it lines up with the state it describes. It is not delayed by a
// cycle.
// ---------------------------------------------------------------------------
module ws2812_ctrl #(
  parameter int LED_NUM = 64,
  parameter int T_BIT   = 62,
  parameter int T0H     = 20,
  parameter int T1H     = 40,
  parameter int T_RST   = 15000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ws2812_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_start,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int CYC_MAX = (T_BIT > T_RST) ? T_BIT : T_RST;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] GAP_LAST  = CYC_W'(T_RST - 1);
  localparam logic [CYC_W-1:0] HIGH_ONE  = CYC_W'(T1H);
  localparam logic [CYC_W-1:0] HIGH_ZERO = CYC_W'(T0H);
  localparam logic [6:0]       PIX_LAST  = 7'(LED_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [23:0]       shift_q, shift_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [6:0]        pixel_cnt_q, pixel_cnt_d;
  logic              pending_q, pending_d;
  logic              dout_q, dout_d;
  logic              cfg_start_q, cfg_start_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  // NOTE: every signal written here gets a default first; any path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    pixel_cnt_d = pixel_cnt_q;
    pending_d   = pending_q;
    cfg_start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ws2812_start) begin
          state_d     = LOAD;
          pixel_cnt_d = '0;
          pending_d   = 1'b0;
        end
      end

      LOAD: begin
        shift_d   = cfg_data;
        bit_cnt_d = '0;
        cyc_cnt_d = '0;
        state_d   = SEND;
      end

      SEND: begin
        if (cyc_cnt_q == BIT_LAST) begin
          cyc_cnt_d = '0;
          shift_d   = {shift_q[22:0], 1'b0};
          if (bit_cnt_q == 5'd23) begin
            // Last bit period of the pixel: ask for the next colour.
            bit_cnt_d   = '0;
            cfg_start_d = 1'b1;
            pixel_cnt_d = pixel_cnt_q + 7'd1;
            state_d     = (pixel_cnt_q < PIX_LAST) ? WAIT : GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end

      // Two idle cycles so cfg_data settles after the index advances.
      WAIT: begin
        if (cyc_cnt_q == CYC_W'(1)) begin
          cyc_cnt_d = '0;
          state_d   = LOAD;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end

      GAP: begin
        if (ws2812_start) pending_d = 1'b1;
        if (cyc_cnt_q == GAP_LAST) begin
          cyc_cnt_d = '0;
          // A request arriving on the frame_done cycle itself still counts.
          if (pending_q || ws2812_start) begin
            state_d     = LOAD;
            pixel_cnt_d = '0;
            pending_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    dout_d       = (state_d == SEND) &&
                   (cyc_cnt_d < (shift_d[23] ? HIGH_ONE : HIGH_ZERO));
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == GAP) && (cyc_cnt_d == GAP_LAST);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      pixel_cnt_q  <= '0;
      pending_q    <= 1'b0;
      dout_q       <= 1'b0;
      cfg_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      pixel_cnt_q  <= pixel_cnt_d;
      pending_q    <= pending_d;
      dout_q       <= dout_d;
      cfg_start_q  <= cfg_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign cfg_start  = cfg_start_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ws2812_ctrl
//
// Bench for ws2812_ctrl with small timing parameters. The bench acts as the
// pixel-select block: it keeps a pixel index that advances on every
// cfg_start and drives cfg_data from that index. The outputs are sampled 1
// time unit after each rising edge. The expected output sequence for each
// cycle comes from a waveform model built from the frame timing rules.
// ---------------------------------------------------------------------------
module tb_ws2812_ctrl;

  localparam int LED_NUM   = 2;
  localparam int T_BIT     = 10;
  localparam int T0H       = 3;
  localparam int T1H       = 7;
  localparam int T_RST     = 20;
  localparam int PIX_LEN   = 1 + 24 * T_BIT;
  localparam int FRAME_LEN = LED_NUM * PIX_LEN + (LED_NUM - 1) * 2 + T_RST;
  localparam int TRACE_N   = 1100;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        ws2812_start;
  logic [23:0] cfg_data;
  logic        cfg_start;
  logic        dout;
  logic        busy;
  logic        frame_done;

  ws2812_ctrl #(
    .LED_NUM(LED_NUM),
    .T_BIT  (T_BIT),
    .T0H    (T0H),
    .T1H    (T1H),
    .T_RST  (T_RST)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .ws2812_start(ws2812_start),
    .cfg_data    (cfg_data),
    .cfg_start   (cfg_start),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic dout;
    logic cfg_start;
    logic busy;
    logic frame_done;
  } smp_t;

  typedef logic [LED_NUM-1:0][23:0] frame_t;

  typedef struct {
    logic [23:0] p0;
    logic [23:0] p1;
    int          exp_high;
    int          exp_busy;
  } vec_t;

  int     errors = 0;
  int     checks = 0;
  smp_t   obs[$];
  smp_t   exp_a[TRACE_N];
  frame_t pix;
  int     idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock: sample outputs, then act as the pixel-select block.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    obs.push_back(smp_t'({dout, cfg_start, busy, frame_done}));
    if (cfg_start === 1'b1) idx = (idx + 1) % LED_NUM;
    cfg_data = pix[idx];
  endtask

  function automatic int count_field(input int field, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < obs.size(); i++) begin
      case (field)
        0:       n += int'(obs[i].dout);
        1:       n += int'(obs[i].cfg_start);
        2:       n += int'(obs[i].busy);
        default: n += int'(obs[i].frame_done);
      endcase
    end
    return n;
  endfunction

  // Reference waveform of one frame starting (LOAD cycle) at trace index off.
  task automatic model_frame(input int off, input frame_t px);
    int   k = off;
    smp_t s;
    for (int p = 0; p < LED_NUM; p++) begin
      if (k < TRACE_N) exp_a[k] = smp_t'(4'b0010);
      k++;
      for (int b = 23; b >= 0; b--) begin
        for (int c = 0; c < T_BIT; c++) begin
          s = '0;
          s.busy = 1'b1;
          s.dout = (c < (px[p][b] ? T1H : T0H));
          if (k < TRACE_N) exp_a[k] = s;
          k++;
        end
      end
      if (p < LED_NUM - 1) begin
        for (int w = 0; w < 2; w++) begin
          s = '0;
          s.busy      = 1'b1;
          s.cfg_start = (w == 0);
          if (k < TRACE_N) exp_a[k] = s;
          k++;
        end
      end else begin
        for (int g = 0; g < T_RST; g++) begin
          s = '0;
          s.busy       = 1'b1;
          s.cfg_start  = (g == 0);
          s.frame_done = (g == T_RST - 1);
          if (k < TRACE_N) exp_a[k] = s;
          k++;
        end
      end
    end
  endtask

  // Frame A starts at index 0. A second request driven before edge s2 is
  // seen by the cycle at index s2-1. It is honoured in the latch gap (the
  // frame then follows at once) or while idle. It is ignored otherwise.
  task automatic build_expected(input int s2, input frame_t pa, input frame_t pb);
    int seen;
    for (int i = 0; i < TRACE_N; i++) exp_a[i] = '0;
    model_frame(0, pa);
    if (s2 > 0) begin
      seen = s2 - 1;
      if (seen >= FRAME_LEN - T_RST && seen <= FRAME_LEN - 1) model_frame(FRAME_LEN, pb);
      else if (seen >= FRAME_LEN) model_frame(s2, pb);
    end
  endtask

  task automatic run_trace(input int n, input int s2, input frame_t pa, input frame_t pb);
    obs.delete();
    pix      = pa;
    idx      = 0;
    cfg_data = pix[0];
    for (int i = 0; i < n; i++) begin
      ws2812_start = (i == 0) || (i == s2);
      if (s2 > 0 && i == s2) pix = pb;
      tick();
    end
    ws2812_start = 1'b0;
  endtask

  task automatic compare_trace(input string name, input int n);
    int bad   = 0;
    int first = -1;
    for (int i = 0; i < n; i++) begin
      if (obs[i] !== exp_a[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0)
      $display("  %s: first divergence at cycle %0d got %b want %b",
               name, first, obs[first], exp_a[first]);
    check(name, bad, 0);
  endtask

  vec_t   vecs[5];
  frame_t fa, fb;
  int     s2;
  int     base;

  initial begin
    vecs[0] = '{24'hA00001, 24'h000000, 156, FRAME_LEN};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 240, FRAME_LEN};
    vecs[2] = '{24'h000000, 24'h000000, 144, FRAME_LEN};
    vecs[3] = '{24'hFFFFFF, 24'hFFFFFF, 336, FRAME_LEN};
    vecs[4] = '{24'h123456, 24'h0F0F0F, 228, FRAME_LEN};

    sys_rst      = 1'b1;
    ws2812_start = 1'b0;
    cfg_data     = '0;
    pix          = '0;
    idx          = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_start", cfg_start, 0);
    check("rst_frame_done", frame_done, 0);
    sys_rst = 1'b0;

    // Idle with no request.
    obs.delete();
    repeat (1000) tick();
    check("idle_dout_high", count_field(0, 0, 999), 0);
    check("idle_cfg_start", count_field(1, 0, 999), 0);
    check("idle_busy", count_field(2, 0, 999), 0);

    // Table of single frames with hand-computed totals.
    foreach (vecs[v]) begin
      fa[0] = vecs[v].p0;
      fa[1] = vecs[v].p1;
      run_trace(FRAME_LEN + 16, -1, fa, fa);
      check($sformatf("vec%0d_high_cycles", v), count_field(0, 0, FRAME_LEN + 15), vecs[v].exp_high);
      check($sformatf("vec%0d_busy_cycles", v), count_field(2, 0, FRAME_LEN + 15), vecs[v].exp_busy);
      check($sformatf("vec%0d_cfg_start", v), count_field(1, 0, FRAME_LEN + 15), LED_NUM);
      check($sformatf("vec%0d_frame_done", v), count_field(3, 0, FRAME_LEN + 15), 1);
    end

    // Bit widths of 24'hA00001 and cfg_start after 240 SEND cycles.
    fa[0] = 24'hA00001;
    fa[1] = 24'h000000;
    run_trace(FRAME_LEN + 16, -1, fa, fa);
    check("a00001_bit23_high", count_field(0, 1, T_BIT), T1H);
    check("a00001_bit22_high", count_field(0, 1 + T_BIT, 2 * T_BIT), T0H);
    check("a00001_bit0_high", count_field(0, 1 + 23 * T_BIT, 24 * T_BIT), T1H);
    check("a00001_cfg_start_at_241", obs[1 + 24 * T_BIT].cfg_start, 1);
    check("a00001_no_early_cfg_start", count_field(1, 0, 24 * T_BIT), 0);

    // Full frame FFFFFF/000000 against the model, including the gap and busy fall.
    fa[0] = 24'hFFFFFF;
    fa[1] = 24'h000000;
    build_expected(-1, fa, fa);
    run_trace(TRACE_N, -1, fa, fa);
    compare_trace("frame_ff_00", TRACE_N);
    check("ff_00_gap_last_done", obs[FRAME_LEN - 1].frame_done, 1);
    check("ff_00_busy_after_done", obs[FRAME_LEN].busy, 0);

    // Request during the gap, and request on the frame_done cycle.
    for (int c = 0; c < 2; c++) begin
      s2 = (c == 0) ? FRAME_LEN - 5 : FRAME_LEN;
      fb[0] = 24'h00FF00;
      fb[1] = 24'h5A5A5A;
      build_expected(s2, fa, fb);
      run_trace(TRACE_N, s2, fa, fb);
      compare_trace($sformatf("pending_%0d", c), TRACE_N);
      check($sformatf("pending_%0d_busy_held", c), count_field(2, 0, 2 * FRAME_LEN - 1), 2 * FRAME_LEN);
      check($sformatf("pending_%0d_frame_done", c), count_field(3, 0, TRACE_N - 1), 2);
    end

    // Request mid-SEND is ignored.
    build_expected(100, fa, fa);
    run_trace(TRACE_N, 100, fa, fa);
    compare_trace("midsend_start", TRACE_N);
    check("midsend_cfg_start", count_field(1, 0, TRACE_N - 1), 2);
    check("midsend_frame_done", count_field(3, 0, TRACE_N - 1), 1);

    // Reset in the middle of the first bit of pixel 0.
    obs.delete();
    fa[0]        = 24'hFFFFFF;
    pix          = fa;
    idx          = 0;
    cfg_data     = pix[0];
    ws2812_start = 1'b1;
    tick();
    ws2812_start = 1'b0;
    repeat (4) tick();
    check("prereset_dout", dout, 1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("midreset_dout", dout, 0);
    check("midreset_busy", busy, 0);
    repeat (3) tick();
    sys_rst = 1'b0;
    obs.delete();
    repeat (600) tick();
    check("aborted_frame_done", count_field(3, 0, 599), 0);
    check("aborted_cfg_start", count_field(1, 0, 599), 0);
    check("aborted_busy", count_field(2, 0, 599), 0);
    build_expected(-1, fa, fa);
    run_trace(TRACE_N, -1, fa, fa);
    compare_trace("after_reset_frame", TRACE_N);

    // Random pixels and randomly placed second requests.
    for (int r = 0; r < 8; r++) begin
      fa[0] = 24'($urandom);
      fa[1] = 24'($urandom);
      fb[0] = 24'($urandom);
      fb[1] = 24'($urandom);
      case (r % 4)
        0:       s2 = -1;
        1:       begin s2 = int'($urandom_range(2, FRAME_LEN - T_RST)); fb = fa; end
        2:       s2 = int'($urandom_range(FRAME_LEN - T_RST + 1, FRAME_LEN));
        default: s2 = int'($urandom_range(FRAME_LEN + 1, FRAME_LEN + 40));
      endcase
      build_expected(s2, fa, fb);
      base = int'($urandom_range(0, 7));
      repeat (base) tick();
      run_trace(TRACE_N, s2, fa, fb);
      compare_trace($sformatf("random_%0d_s2_%0d", r, s2), TRACE_N);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
